// File: rtl/strobe_decoder.sv
// strobe_decoder: clocked, parametrised address-to-select decoder with a
// req/ready handshake and a timed, active-low select strobe.
//
// A transaction runs IDLE -> SETUP -> ACTIVE -> HOLD -> IDLE. SETUP and HOLD
// are skipped when their cycle counts are zero. During ACTIVE the select line
// of the latched address is held low for PULSE_CYC cycles.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   synchronous active-high reset
//   req    in   request, accepted when ready is high
//   addr   in   select address, latched on accept
//   _en    in   active-low enable; high at accept suppresses the strobe,
//               high during ACTIVE cuts the strobe short
//   ready  out  high in IDLE
//   busy   out  high in SETUP, ACTIVE and HOLD
//   _y     out  active-low one-cold selects
//   done   out  one-cycle pulse in the first IDLE cycle after a transaction
//   err    out  with done: latched address was >= NOUT
//   abort  out  with done: strobe was suppressed or cut short by _en
module strobe_decoder #(
  parameter int ABITS     = 4,
  parameter int NOUT      = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [ABITS-1:0] addr,
  input  logic             _en,
  output logic             ready,
  output logic             busy,
  output logic [NOUT-1:0]  _y,
  output logic             done,
  output logic             err,
  output logic             abort
);

  localparam int MAXC_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC    = (MAXC_SP > HOLD_CYC) ? MAXC_SP : HOLD_CYC;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SETUP_RL = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] PULSE_RL = CW'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
  localparam logic [CW-1:0] HOLD_RL  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  localparam logic [ABITS:0]  NOUT_X = (ABITS + 1)'(NOUT);
  localparam logic [NOUT-1:0] ONE    = NOUT'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACTIVE,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ABITS-1:0] sel_q, sel_d;
  logic             oor_q, oor_d;   // latched address out of range
  logic             sup_q, sup_d;   // strobe suppressed/aborted by _en

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [NOUT-1:0]  y_q, y_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;

  // Next-state and next-output logic. Outputs are computed from the next
  // state so that each output is a plain flop and never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    oor_d   = oor_q;
    sup_d   = sup_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          sel_d = addr;
          oor_d = ({1'b0, addr} >= NOUT_X);
          sup_d = _en;
          if (SETUP_CYC > 0) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_RL;
          end else begin
            state_d = S_ACTIVE;
            cnt_d   = PULSE_RL;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
          cnt_d   = PULSE_RL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACTIVE: begin
        // A live strobe is cut short by _en; an already suppressed or
        // out-of-range transaction just runs out its full timeline.
        if ((_en && !sup_q && !oor_q) || (cnt_q == '0)) begin
          if (_en && !sup_q && !oor_q) sup_d = 1'b1;
          if (HOLD_CYC > 0) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_RL;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = !ready_d;
    done_d  = ready_d && (state_q != S_IDLE);
    err_d   = done_d && oor_d;
    abort_d = done_d && sup_d;
    y_d     = '1;
    if ((state_d == S_ACTIVE) && !sup_d && !oor_d) y_d = ~(ONE << sel_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      oor_q   <= 1'b0;
      sup_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      y_q     <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      oor_q   <= oor_d;
      sup_q   <= sup_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      y_q     <= y_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign _y    = y_q;
  assign done  = done_q;
  assign err   = err_q;
  assign abort = abort_q;

endmodule
